btn_conditioner: RTL and testbench

Front-end conditioner for the board push-buttons. Sits directly upstream of the run/stop/clear button FSM that drives the UART upcounter. For each raw button it:
- synchronises the pin into the clk domain,
- debounces it with a shared sampling tick,
- outputs a clean level plus one-cycle rise and fall pulses.

The run/stop input consumes the rise pulse; the clear input consumes the debounced level.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 67 ++++++
 rtl/btn_conditioner.sv | 59 +++++
 tb/tb_btn_conditioner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioner.
package btn_pkg;

  localparam int unsigned DEF_CLK_HZ    = 100_000_000;
  localparam int unsigned DEF_SAMPLE_HZ = 1_000;

  // Board channel indices
  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_U = 1;

  // Clock cycles per debounce sample
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, sample shift register,
// debounced level and one-cycle rise/fall pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned SW = STABLE_SAMPLES;

  logic [1:0]    sync_q;
  logic [SW-1:0] shreg_q;
  logic [SW-1:0] shreg_d;
  logic [SW-1:0] nxt;
  logic          level_d;
  logic          rise_d;
  logic          fall_d;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pin};
  end

  // Shift in a sample on each tick; change level only on a full run
  always_comb begin
    shreg_d = shreg_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    nxt     = {shreg_q[SW-2:0], sync_q[1]};
    if (tick) begin
      shreg_d = nxt;
      if ((&nxt) && !level) begin
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else if (!(|nxt) && level) begin
        level_d = 1'b0;
        fall_d  = 1'b0 | 1'b1;
      end
    end
  end

  // Debounce state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: shared sample-tick divider feeding N_BTN
// independent debounce channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN          = 2,
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned SAMPLE_HZ      = DEF_SAMPLE_HZ,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("btn_conditioner: CLK_HZ/SAMPLE_HZ must be >= 2");
  end
  if (STABLE_SAMPLES < 2) begin : g_bad_stable
    $error("btn_conditioner: STABLE_SAMPLES must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_c;

  // Divider next state; tick on the last count of each period
  always_comb begin
    tick_c = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Divider counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .pin  (i_btn[i]),
      .tick (tick_c),
      .level(o_level[i]),
      .rise (o_rise[i]),
      .fall (o_fall[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DIV=10, 4 stable samples).
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int unsigned N      = 2;
  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned SMP_HZ = 100;
  localparam int unsigned SS     = 4;
  localparam int          DIV    = int'(CLK_HZ / SMP_HZ);

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_level;
  logic [N-1:0] o_rise;
  logic [N-1:0] o_fall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SMP_HZ), .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall)
  );

  // Reference model: samples taken every DIV edges of the pin as seen
  // two edges earlier; a level flips after SS equal samples in a row.
  int           e_cnt;
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, m_rise, m_fall;
  logic         run_val[N];
  int           run_len[N];
  int           rise_cnt[N];
  int           fall_cnt[N];

  task automatic model_reset();
    e_cnt = 0;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_level = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < int'(N); i++) begin
      run_val[i] = 1'b0;
      run_len[i] = int'(SS);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] smp;
    if (reset) begin
      model_reset();
      return;
    end
    e_cnt++;
    hist.push_back(i_btn);
    smp = hist.pop_front();
    m_rise = '0;
    m_fall = '0;
    if (e_cnt % DIV == 0) begin
      for (int i = 0; i < int'(N); i++) begin
        if (smp[i] == run_val[i]) run_len[i]++;
        else begin
          run_val[i] = smp[i];
          run_len[i] = 1;
        end
        if (run_len[i] >= int'(SS) && run_val[i] != m_level[i]) begin
          m_level[i] = run_val[i];
          if (run_val[i]) m_rise[i] = 1'b1;
          else            m_fall[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [N-1:0] el,
                            input logic [N-1:0] er, input logic [N-1:0] ef);
    n_tests++;
    if (o_level !== el || o_rise !== er || o_fall !== ef) begin
      n_fail++;
      $display("FAIL %s @e%0d: got lvl=%b rise=%b fall=%b, expected lvl=%b rise=%b fall=%b",
               name, e_cnt, o_level, o_rise, o_fall, el, er, ef);
    end
  endtask

  // One clock: advance model at the edge, compare at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs("cycle", m_level, m_rise, m_fall);
    for (int i = 0; i < int'(N); i++) begin
      rise_cnt[i] += int'(o_rise[i]);
      fall_cnt[i] += int'(o_fall[i]);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until a rise on ch; lat counts edges from the next edge as 1
  task automatic wait_rise(input int ch, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (o_rise[ch]) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] btn;
    int           cycles;
    logic [N-1:0] exp_level;
    int           exp_rise[N];
    int           exp_fall[N];
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, e0, t1, r0, f0, r1, f1;

    vecs[0] = '{btn: 2'b00, cycles: 200, exp_level: 2'b00, exp_rise: '{0, 0}, exp_fall: '{0, 0}};
    vecs[1] = '{btn: 2'b10, cycles: 25,  exp_level: 2'b00, exp_rise: '{0, 0}, exp_fall: '{0, 0}};
    vecs[2] = '{btn: 2'b00, cycles: 60,  exp_level: 2'b00, exp_rise: '{0, 0}, exp_fall: '{0, 0}};
    vecs[3] = '{btn: 2'b11, cycles: 60,  exp_level: 2'b11, exp_rise: '{1, 1}, exp_fall: '{0, 0}};
    vecs[4] = '{btn: 2'b00, cycles: 60,  exp_level: 2'b00, exp_rise: '{0, 0}, exp_fall: '{1, 1}};

    for (int i = 0; i < int'(N); i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_outs("reset_state", '0, '0, '0);
    reset = 1'b0;
    model_reset();

    // Directed table: idle, glitch on btnu, simultaneous press/release
    for (int v = 0; v < 5; v++) begin
      int r_b[N], f_b[N];
      for (int i = 0; i < int'(N); i++) begin
        r_b[i] = rise_cnt[i];
        f_b[i] = fall_cnt[i];
      end
      i_btn = vecs[v].btn;
      run(vecs[v].cycles);
      check_int($sformatf("vec%0d_level", v), int'(o_level), int'(vecs[v].exp_level));
      for (int i = 0; i < int'(N); i++) begin
        check_int($sformatf("vec%0d_rise%0d", v, i), rise_cnt[i] - r_b[i], vecs[v].exp_rise[i]);
        check_int($sformatf("vec%0d_fall%0d", v, i), fall_cnt[i] - f_b[i], vecs[v].exp_fall[i]);
      end
    end

    // Clean step on btnr at three tick phases, exact latency
    for (int ph = 0; ph < 3; ph++) begin
      run(ph * 3 + 1);
      i_btn[BTN_R] = 1'b1;
      e0 = e_cnt + 1;
      t1 = ((e0 + 2 + DIV - 1) / DIV) * DIV;
      wait_rise(int'(BTN_R), 60, lat);
      check_int($sformatf("step%0d_latency", ph), lat, t1 + (int'(SS) - 1) * DIV - e0 + 1);
      check_int($sformatf("step%0d_lat_in_range", ph), int'(lat >= 33 && lat <= 42), 1);
      step();
      check_int($sformatf("step%0d_rise_width", ph), int'(o_rise[BTN_R]), 0);
      f0 = fall_cnt[BTN_R];
      i_btn[BTN_R] = 1'b0;
      run(60);
      check_int($sformatf("step%0d_fall_count", ph), fall_cnt[BTN_R] - f0, 1);
    end

    // Bounce: toggle every 7 cycles for 60 cycles, then hold pressed
    r0 = rise_cnt[BTN_R];
    f0 = fall_cnt[BTN_R];
    for (int k = 0; k < 60; k++) begin
      i_btn[BTN_R] = ((k / 7) % 2 == 0);
      step();
    end
    i_btn[BTN_R] = 1'b1;
    run(42);
    check_int("bounce_level", int'(o_level[BTN_R]), 1);
    run(20);
    check_int("bounce_rise_count", rise_cnt[BTN_R] - r0, 1);
    check_int("bounce_fall_count", fall_cnt[BTN_R] - f0, 0);

    // Reset mid-period while btnr is held high and debounced
    while (e_cnt % DIV != 4) step();
    reset = 1'b1;
    #1;
    check_outs("async_reset", '0, '0, '0);
    model_reset();
    run(3);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    wait_rise(int'(BTN_R), 60, lat);
    check_int("post_reset_latency", lat, DIV + (int'(SS) - 1) * DIV);
    check_int("post_reset_range", int'(lat >= 33 && lat <= 42), 1);
    i_btn = '0;
    run(60);

    // Randomised segments against the model
    r1 = rise_cnt[BTN_U];
    f1 = fall_cnt[BTN_U];
    for (int s = 0; s < 60; s++) begin
      i_btn = N'($urandom);
      run(int'($urandom_range(1, 55)));
      check_int($sformatf("rand%0d_no_double", s), int'(|(o_rise & o_fall)), 0);
    end
    i_btn = '0;
    run(60);
    check_int("rand_final_level", int'(o_level), 0);
    check_int("rand_u_balanced", rise_cnt[BTN_U] - r1, fall_cnt[BTN_U] - f1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
